// File: rtl/multi_bus_sync.sv
`timescale 1ns/1ps
// multi_bus_sync
// Synchronises NUM_CH independent qualified buses into the i_clk domain and
// merges the captured words into one valid/ready stream with round-robin
// arbitration. Each channel has a one-entry pending slot. If a new event
// arrives before the slot drains, the slot keeps only the newest word and
// the channel's sticky overrun flag is set.
//
// Ports
//   i_clk           destination clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_unsync_bus    NUM_CH packed buses, channel c at [c*BUS_WIDTH +: BUS_WIDTH]
//   i_bus_enable    per-channel unsynchronised qualifier
//   o_sync_bus      per-channel captured bus, same packing as i_unsync_bus
//   o_enable_pulse  per-channel one-cycle pulse, aligned with o_sync_bus update
//   o_out_valid     merged stream valid
//   i_out_ready     merged stream ready
//   o_out_data      merged stream data
//   o_out_ch        source channel of o_out_data
//   o_overrun       sticky per-channel overrun flags
//   i_ovr_clr       synchronous clear of all overrun flags
module multi_bus_sync #(
    parameter int NUM_STAGES  = 2,
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_CH      = 4,
    parameter int TOGGLE_MODE = 0,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_CH*BUS_WIDTH-1:0] i_unsync_bus,
    input  logic [NUM_CH-1:0]           i_bus_enable,
    output logic [NUM_CH*BUS_WIDTH-1:0] o_sync_bus,
    output logic [NUM_CH-1:0]           o_enable_pulse,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [BUS_WIDTH-1:0]        o_out_data,
    output logic [CH_W-1:0]             o_out_ch,
    output logic [NUM_CH-1:0]           o_overrun,
    input  logic                        i_ovr_clr
);

    logic [NUM_STAGES-1:0]       r_sync [NUM_CH];
    logic [NUM_CH-1:0]           r_prev;
    logic [NUM_CH*BUS_WIDTH-1:0] r_sync_bus;
    logic [NUM_CH-1:0]           r_enable_pulse;
    logic [NUM_CH-1:0]           r_pend;
    logic [BUS_WIDTH-1:0]        r_pend_data [NUM_CH];
    logic [NUM_CH-1:0]           r_overrun;
    logic                        r_out_valid;
    logic [BUS_WIDTH-1:0]        r_out_data;
    logic [CH_W-1:0]             r_out_ch;
    logic [CH_W-1:0]             r_last_grant;

    logic [NUM_CH-1:0]           w_s;
    logic [NUM_CH-1:0]           w_evt;
    logic [NUM_CH-1:0]           w_ovr_set;
    logic [NUM_CH-1:0]           w_gnt_vec;
    logic                        w_load;
    logic                        w_hi_found;
    logic                        w_lo_found;
    logic [CH_W-1:0]             w_hi_idx;
    logic [CH_W-1:0]             w_lo_idx;
    logic [CH_W-1:0]             w_gnt_idx;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_s[c] = r_sync[c][NUM_STAGES-1];
        end
    end

    assign w_evt = (TOGGLE_MODE != 0) ? (w_s ^ r_prev) : (w_s & ~r_prev);

    // Round-robin: the first pending channel above last_grant wins; if none
    // is above it, wrap to the lowest pending channel.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_pend[c]) begin
                if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = CH_W'(c);
                end
                if (!w_hi_found && (c > int'(r_last_grant))) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = CH_W'(c);
                end
            end
        end
        w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        w_load    = (|r_pend) && (!r_out_valid || i_out_ready);
        w_gnt_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_gnt_vec[c] = w_load && (w_gnt_idx == CH_W'(c));
        end
    end

    // A channel granted in the same cycle as its new event vacates the slot
    // first, so the new word lands in an empty slot and is not an overrun.
    assign w_ovr_set = w_evt & r_pend & ~w_gnt_vec;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_sync[c]      <= '0;
                r_pend_data[c] <= '0;
            end
            r_prev         <= '0;
            r_sync_bus     <= '0;
            r_enable_pulse <= '0;
            r_pend         <= '0;
            r_overrun      <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_sync[c] <= {r_sync[c][NUM_STAGES-2:0], i_bus_enable[c]};
                if (w_evt[c]) begin
                    r_sync_bus[c*BUS_WIDTH +: BUS_WIDTH] <= i_unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
                    r_pend_data[c]                       <= i_unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
                    r_pend[c]                            <= 1'b1;
                end else if (w_gnt_vec[c]) begin
                    r_pend[c] <= 1'b0;
                end
            end
            r_prev         <= w_s;
            r_enable_pulse <= w_evt;
            r_overrun      <= (r_overrun & ~{NUM_CH{i_ovr_clr}}) | w_ovr_set;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_last_grant <= CH_W'(NUM_CH - 1);
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= r_pend_data[w_gnt_idx];
            r_out_ch     <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_sync_bus     = r_sync_bus;
    assign o_enable_pulse = r_enable_pulse;
    assign o_out_valid    = r_out_valid;
    assign o_out_data     = r_out_data;
    assign o_out_ch       = r_out_ch;
    assign o_overrun      = r_overrun;

endmodule

// File: doc/multi_bus_sync.md
MULTI_BUS_SYNC -- requirements
Module: multi_bus_sync

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2, enable-synchroniser depth; legal values >= 2.
REQ-002 SHALL have parameter BUS_WIDTH, default 8, width of each channel bus; legal values >= 1.
REQ-003 SHALL have parameter NUM_CH, default 4, number of independent channels; legal values >= 1.
REQ-004 SHALL have parameter TOGGLE_MODE, default 0; 0 = rising edge of bus_enable is an event, 1 = any transition is an event.
REQ-005 SHALL derive CH_W = max(1, clog2(NUM_CH)).
REQ-006 CLK  input  1  single destination clock, rising edge; the block has one clock only.
REQ-007 RST  input  1  reset, asynchronous assert, active-low.
REQ-008 unsync_bus  input  NUM_CH*BUS_WIDTH  unsynchronised buses; channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH].
REQ-009 bus_enable  input  NUM_CH  per-channel unsynchronised valid/qualifier.
REQ-010 sync_bus  output  NUM_CH*BUS_WIDTH  per-channel synchronised bus, registered, same packing as unsync_bus.
REQ-011 enable_pulse  output  NUM_CH  per-channel one-cycle registered pulse, aligned with the sync_bus update.
REQ-012 out_valid  output  1  merged stream valid.
REQ-013 out_ready  input  1  merged stream ready from consumer.
REQ-014 out_data  output  BUS_WIDTH  merged stream data.
REQ-015 out_ch  output  CH_W  source channel of out_data.
REQ-016 overrun  output  NUM_CH  sticky per-channel overrun flag.
REQ-017 ovr_clr  input  1  synchronous clear of all overrun bits.

Function
REQ-018 Each channel SHALL pass bus_enable through a NUM_STAGES flop chain; the last stage is s[c].
REQ-019 Each channel SHALL register s[c] into prev[c] every cycle.
REQ-020 The channel event SHALL be s & !prev when TOGGLE_MODE=0, and s ^ prev when TOGGLE_MODE=1.
REQ-021 On an event edge the channel SHALL load its unsync_bus slice into sync_bus[c] and set enable_pulse[c] for exactly one cycle.
REQ-022 Without an event, sync_bus[c] SHALL hold.
REQ-023 Latency: if bus_enable[c] is first sampled high at edge E0, then sync_bus[c] and enable_pulse[c] SHALL update at edge E0+NUM_STAGES.
REQ-024 Each channel SHALL own a one-entry pending slot: pend[c] plus pend_data[c]; an event sets pend[c] and loads pend_data[c] with the same value captured into sync_bus.
REQ-025 The merged output register SHALL load when out_valid=0 or when out_valid&out_ready, provided any pend bit is set.
REQ-026 A load SHALL select the first set pend bit in round-robin order starting at last_grant+1 (mod NUM_CH), copy pend_data to out_data, set out_ch, set out_valid, clear that pend bit, and update last_grant.
REQ-027 out_valid SHALL drop after out_valid&out_ready when no pend bit is set.
REQ-028 While out_valid&!out_ready, out_valid, out_data and out_ch SHALL remain stable.
REQ-029 Throughput: with out_ready held at 1, the block SHALL issue one transfer per cycle.
REQ-030 Overrun: an event on channel c while pend[c]=1 and c is not granted that cycle SHALL overwrite pend_data[c] (newest wins) and set overrun[c].
REQ-031 An event on the same cycle that channel c is granted SHALL send the old data, leave pend[c]=1 with the new data, and not set overrun.
REQ-032 overrun bits SHALL stay set until an ovr_clr cycle; ovr_clr together with a new overrun on the same channel leaves that bit set (set wins).
REQ-033 With NUM_CH=1, out_ch SHALL be constant 0 and arbitration SHALL be trivial.

Reset
REQ-034 RST low SHALL asynchronously clear all sync chains, prev, sync_bus, enable_pulse, pend, pend_data, out_valid, out_data, out_ch and overrun to 0.
REQ-035 RST low SHALL set last_grant to NUM_CH-1, so channel 0 has first priority after reset.
REQ-036 Reset asserted mid-transfer SHALL discard pending and held data; there is no replay after release.
REQ-037 After RST release, a bus_enable already high SHALL produce one event in TOGGLE_MODE=0 (prev=0) and one event in TOGGLE_MODE=1.

Verification
REQ-038 Defaults, ch0 bus=0xA5 with bus_enable 0->1 at edge E0, out_ready=1 -> sync_bus[0]=0xA5 and enable_pulse[0]=1 at E0+2; out_valid=1, out_ch=0, out_data=0xA5 at E0+3 for one cycle.
REQ-039 Events on all 4 channels in the same cycle, out_ready=1 -> outputs ch0, ch1, ch2, ch3 on 4 consecutive cycles, no overrun.
REQ-040 out_ready=0, ch2 events with 0x11 then 0x22 (out register empty) -> out shows 0x11 held stable; 0x22 sits pending, overrun[2]=0; a third event 0x33 -> overrun[2]=1; after ready, second transfer is 0x33.
REQ-041 TOGGLE_MODE=1, bus_enable[1] toggles 0->1->0 spaced 5 cycles -> two enable_pulse[1] pulses and two transfers; with TOGGLE_MODE=0 the same stimulus -> one pulse.
REQ-042 Round-robin: ch0 and ch3 event continuously with out_ready=1 -> out_ch alternates 0,3,0,3; neither channel starves.
REQ-043 RST asserted while out_valid=1 and pend bits set -> all outputs 0 immediately; no transfer after release until a new event.
